// File: rtl/load_store_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : load_store_unit_if                                         |
// | Brief    : Request/response handshake and word-memory trigger bus     |
// |            between the MEM stage, the load/store unit and data memory.|
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
interface load_store_unit_if #(
    parameter int IDX_W = 7
);
    logic             req_valid;
    logic             req_ready;
    logic [5:0]       req_op;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic             resp_valid;
    logic [31:0]      resp_rdata;
    logic [1:0]       resp_fault;
    logic [IDX_W-1:0] mem_read_addr;
    logic [IDX_W-1:0] mem_write_addr;
    logic [31:0]      mem_write_data;
    logic             mem_trig_read;
    logic             mem_trig_write;
    logic [31:0]      mem_read_data;

    // Environment side: requester plus the data memory.
    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_read_addr, mem_write_addr, mem_write_data,
        input  mem_trig_read, mem_trig_write
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_read_addr, mem_write_addr, mem_write_data,
        output mem_trig_read, mem_trig_write
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : load_store_unit                                            |
// | Brief    : MEM-stage front end: byte-addressed MIPS loads/stores to   |
// |            word trigger pulses, sub-word RMW and load extension.      |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module load_store_unit #(
    parameter int MEM_WORDS = 128,
    parameter int IDX_W     = 7
) (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);
    localparam logic [5:0] c_OP_LB  = 6'b100000;
    localparam logic [5:0] c_OP_LH  = 6'b100001;
    localparam logic [5:0] c_OP_LW  = 6'b100011;
    localparam logic [5:0] c_OP_LBU = 6'b100100;
    localparam logic [5:0] c_OP_LHU = 6'b100101;
    localparam logic [5:0] c_OP_SB  = 6'b101000;
    localparam logic [5:0] c_OP_SH  = 6'b101001;
    localparam logic [5:0] c_OP_SW  = 6'b101011;

    localparam logic [1:0] c_FLT_OK    = 2'b00;
    localparam logic [1:0] c_FLT_ALIGN = 2'b01;
    localparam logic [1:0] c_FLT_RANGE = 2'b10;
    localparam logic [1:0] c_FLT_OP    = 2'b11;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_RD   = 3'd1;
    localparam logic [2:0] c_ST_CAP  = 3'd2;
    localparam logic [2:0] c_ST_WR   = 3'd3;
    localparam logic [2:0] c_ST_RESP = 3'd4;

    localparam int          c_AW         = IDX_W + 2;
    localparam logic [31:0] c_ADDR_LIMIT = 32'(MEM_WORDS * 4);

    logic [2:0]       r_state,      w_state;
    logic [5:0]       r_op,         w_op;
    logic [c_AW-1:0]  r_addr,       w_addr;
    logic [15:0]      r_wdata,      w_wdata;
    logic [31:0]      r_resp_rdata, w_resp_rdata;
    logic [1:0]       r_resp_fault, w_resp_fault;
    logic [IDX_W-1:0] r_rd_addr,    w_rd_addr;
    logic [IDX_W-1:0] r_wr_addr,    w_wr_addr;
    logic [31:0]      r_wr_data,    w_wr_data;
    logic             r_req_ready;
    logic             r_resp_valid;
    logic             r_trig_rd;
    logic             r_trig_wr;

    logic             w_accept;
    logic             w_legal;
    logic             w_is_half;
    logic             w_is_word;
    logic             w_out_of_range;
    logic [1:0]       w_req_fault;
    logic             w_op_is_load;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;
    logic [31:0]      w_merged;

    assign w_accept       = bus.req_valid & r_req_ready;
    assign w_out_of_range = (bus.req_addr >= c_ADDR_LIMIT);

    always_comb begin
        w_legal   = 1'b0;
        w_is_half = 1'b0;
        w_is_word = 1'b0;
        case (bus.req_op)
            c_OP_LB, c_OP_LBU, c_OP_SB: w_legal = 1'b1;
            c_OP_LH, c_OP_LHU, c_OP_SH: begin
                w_legal   = 1'b1;
                w_is_half = 1'b1;
            end
            c_OP_LW, c_OP_SW: begin
                w_legal   = 1'b1;
                w_is_word = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Illegal opcode outranks range, which outranks alignment.
    always_comb begin
        w_req_fault = c_FLT_OK;
        if (!w_legal) begin
            w_req_fault = c_FLT_OP;
        end else if (w_out_of_range) begin
            w_req_fault = c_FLT_RANGE;
        end else if ((w_is_half && bus.req_addr[0]) ||
                     (w_is_word && (bus.req_addr[1:0] != 2'b00))) begin
            w_req_fault = c_FLT_ALIGN;
        end
    end

    assign w_op_is_load = (r_op == c_OP_LB)  || (r_op == c_OP_LH) ||
                          (r_op == c_OP_LW)  || (r_op == c_OP_LBU) ||
                          (r_op == c_OP_LHU);

    // Big-endian lanes: offset 0 is the most significant byte/half.
    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = bus.mem_read_data[31:24];
            2'd1:    w_byte = bus.mem_read_data[23:16];
            2'd2:    w_byte = bus.mem_read_data[15:8];
            default: w_byte = bus.mem_read_data[7:0];
        endcase
        w_half = r_addr[1] ? bus.mem_read_data[15:0] : bus.mem_read_data[31:16];
        case (r_op)
            c_OP_LB:  w_load = {{24{w_byte[7]}}, w_byte};
            c_OP_LBU: w_load = {24'd0, w_byte};
            c_OP_LH:  w_load = {{16{w_half[15]}}, w_half};
            c_OP_LHU: w_load = {16'd0, w_half};
            default:  w_load = bus.mem_read_data;
        endcase
    end

    always_comb begin
        w_merged = bus.mem_read_data;
        if (r_op == c_OP_SB) begin
            case (r_addr[1:0])
                2'd0:    w_merged[31:24] = r_wdata[7:0];
                2'd1:    w_merged[23:16] = r_wdata[7:0];
                2'd2:    w_merged[15:8]  = r_wdata[7:0];
                default: w_merged[7:0]   = r_wdata[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merged[15:0] = r_wdata;
        end else begin
            w_merged[31:16] = r_wdata;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_op         = r_op;
        w_addr       = r_addr;
        w_wdata      = r_wdata;
        w_resp_rdata = 32'd0;
        w_resp_fault = c_FLT_OK;
        w_rd_addr    = r_rd_addr;
        w_wr_addr    = r_wr_addr;
        w_wr_data    = r_wr_data;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_op    = bus.req_op;
                    w_addr  = bus.req_addr[c_AW-1:0];
                    w_wdata = bus.req_wdata[15:0];
                    if (w_req_fault != c_FLT_OK) begin
                        w_state      = c_ST_RESP;
                        w_resp_fault = w_req_fault;
                    end else if (bus.req_op == c_OP_SW) begin
                        w_state   = c_ST_WR;
                        w_wr_addr = bus.req_addr[c_AW-1:2];
                        w_wr_data = bus.req_wdata;
                    end else begin
                        w_state   = c_ST_RD;
                        w_rd_addr = bus.req_addr[c_AW-1:2];
                    end
                end
            end
            c_ST_RD: w_state = c_ST_CAP;
            c_ST_CAP: begin
                if (w_op_is_load) begin
                    w_state      = c_ST_RESP;
                    w_resp_rdata = w_load;
                end else begin
                    w_state   = c_ST_WR;
                    w_wr_addr = r_addr[c_AW-1:2];
                    w_wr_data = w_merged;
                end
            end
            c_ST_WR:   w_state = c_ST_RESP;
            c_ST_RESP: w_state = c_ST_IDLE;
            default:   w_state = c_ST_IDLE;
        endcase
    end

    // Every output is a register whose value is decided by the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_op         <= 6'd0;
            r_addr       <= '0;
            r_wdata      <= 16'd0;
            r_resp_rdata <= 32'd0;
            r_resp_fault <= c_FLT_OK;
            r_rd_addr    <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= 32'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_trig_rd    <= 1'b0;
            r_trig_wr    <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_op         <= w_op;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            r_resp_rdata <= w_resp_rdata;
            r_resp_fault <= w_resp_fault;
            r_rd_addr    <= w_rd_addr;
            r_wr_addr    <= w_wr_addr;
            r_wr_data    <= w_wr_data;
            r_req_ready  <= (w_state == c_ST_IDLE);
            r_resp_valid <= (w_state == c_ST_RESP);
            r_trig_rd    <= (w_state == c_ST_RD);
            r_trig_wr    <= (w_state == c_ST_WR);
        end
    end

    assign bus.req_ready      = r_req_ready;
    assign bus.resp_valid     = r_resp_valid;
    assign bus.resp_rdata     = r_resp_rdata;
    assign bus.resp_fault     = r_resp_fault;
    assign bus.mem_read_addr  = r_rd_addr;
    assign bus.mem_write_addr = r_wr_addr;
    assign bus.mem_write_data = r_wr_data;
    assign bus.mem_trig_read  = r_trig_rd;
    assign bus.mem_trig_write = r_trig_wr;
endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_load_store_unit                                         |
// | Brief    : Randomised bench for load_store_unit with a word-level     |
// |            memory, an arithmetic reference model and directed cases.  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_load_store_unit;
    localparam logic [5:0] c_LB  = 6'b100000;
    localparam logic [5:0] c_LH  = 6'b100001;
    localparam logic [5:0] c_LW  = 6'b100011;
    localparam logic [5:0] c_LBU = 6'b100100;
    localparam logic [5:0] c_LHU = 6'b100101;
    localparam logic [5:0] c_SB  = 6'b101000;
    localparam logic [5:0] c_SH  = 6'b101001;
    localparam logic [5:0] c_SW  = 6'b101011;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    load_store_unit_if #(.IDX_W(7)) bus ();
    load_store_unit #(.MEM_WORDS(128), .IDX_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          failures = 0;
    bit          check_en = 1'b0;
    logic [31:0] seed_mem [128];
    logic [31:0] dmem [128];
    logic [31:0] mdl_mem [128];
    logic [5:0]  ops [8] = '{c_LB, c_LH, c_LW, c_LBU, c_LHU, c_SB, c_SH, c_SW};

    int          k = 0;
    int          resp_at = -1, rd_at = -1, wr_at = -1, busy_until = -1;
    int          accepts = 0;
    logic [31:0] e_rdata, e_wdata;
    logic [1:0]  e_fault;
    logic [6:0]  e_idx;
    bit          prev_rd = 1'b0, prev_wr = 1'b0;
    logic [1:0]  m_f;
    logic [31:0] m_rd, m_nw;
    int          m_lat;
    bit          m_rds, m_wrs;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Outcome of one request from the ISA rules alone: fault, load value,
    // resulting memory word, latency and which memory accesses it makes.
    function automatic void model(input logic [5:0] op, input logic [31:0] a,
            input logic [31:0] w, input logic [31:0] word,
            output logic [1:0] f, output logic [31:0] rd, output logic [31:0] nw,
            output int lat, output bit rds, output bit wrs);
        int size, off, sh;
        bit ld, sx, legal;
        longint unsigned mask, val;
        legal = 1'b1; ld = 1'b0; sx = 1'b0; size = 4;
        case (op)
            c_LB:    begin size = 1; ld = 1'b1; sx = 1'b1; end
            c_LH:    begin size = 2; ld = 1'b1; sx = 1'b1; end
            c_LW:    begin size = 4; ld = 1'b1; end
            c_LBU:   begin size = 1; ld = 1'b1; end
            c_LHU:   begin size = 2; ld = 1'b1; end
            c_SB:    size = 1;
            c_SH:    size = 2;
            c_SW:    size = 4;
            default: legal = 1'b0;
        endcase
        f = 2'b00; rd = 32'd0; nw = word; rds = 1'b0; wrs = 1'b0; lat = 1;
        off = int'(a % 4);
        if (!legal)              f = 2'b11;
        else if (a > 32'h1FF)    f = 2'b10;
        else if (off % size != 0) f = 2'b01;
        if (f != 2'b00) return;
        sh   = 8 * (4 - size - off);
        mask = (64'd1 << (8 * size)) - 64'd1;
        val  = ({32'd0, word} >> sh) & mask;
        if (ld) begin
            if (sx && (((val >> (8 * size - 1)) & 64'd1) == 64'd1))
                val = val + ((64'd1 << 32) - (64'd1 << (8 * size)));
            rd  = val[31:0];
            rds = 1'b1;
            lat = 3;
        end else begin
            val = ({32'd0, word} & ~(mask << sh)) | (({32'd0, w} & mask) << sh);
            nw  = val[31:0];
            wrs = 1'b1;
            if (size == 4) lat = 2;
            else begin rds = 1'b1; lat = 4; end
        end
    endfunction

    // Data memory: acts once per trigger pulse, mid-cycle.
    always @(negedge clk) begin
        if (!check_en) begin
            for (int i = 0; i < 128; i++) dmem[i] <= seed_mem[i];
        end else begin
            if (bus.mem_trig_read)  bus.mem_read_data <= dmem[bus.mem_read_addr];
            if (bus.mem_trig_write) dmem[bus.mem_write_addr] <= bus.mem_write_data;
        end
    end

    // Cycle-by-cycle comparison against the model's scheduled events.
    always @(negedge clk) begin
        k = k + 1;
        if (!check_en) begin
            for (int i = 0; i < 128; i++) mdl_mem[i] = seed_mem[i];
        end else begin
            chk("req_ready", 32'(bus.req_ready), 32'(k > busy_until));
            chk("resp_valid", 32'(bus.resp_valid), 32'(k == resp_at));
            if (k == resp_at) begin
                chk("resp_rdata", bus.resp_rdata, e_rdata);
                chk("resp_fault", 32'(bus.resp_fault), 32'(e_fault));
            end
            chk("trig_read", 32'(bus.mem_trig_read), 32'(k == rd_at));
            if (k == rd_at) chk("read_addr", 32'(bus.mem_read_addr), 32'(e_idx));
            chk("trig_write", 32'(bus.mem_trig_write), 32'(k == wr_at));
            if (k == wr_at) begin
                chk("write_addr", 32'(bus.mem_write_addr), 32'(e_idx));
                chk("write_data", bus.mem_write_data, e_wdata);
                mdl_mem[e_idx] = e_wdata;
            end
            chk("trig_overlap", 32'(bus.mem_trig_read & bus.mem_trig_write), 32'd0);
            chk("trig_width", 32'((bus.mem_trig_read & prev_rd) | (bus.mem_trig_write & prev_wr)), 32'd0);
            if (reset) begin
                resp_at = -1;
                if (rd_at > k) rd_at = -1;
                if (wr_at > k) wr_at = -1;
                busy_until = k;
            end else if (bus.req_valid && bus.req_ready) begin
                model(bus.req_op, bus.req_addr, bus.req_wdata, mdl_mem[bus.req_addr[8:2]],
                      m_f, m_rd, m_nw, m_lat, m_rds, m_wrs);
                e_idx      = bus.req_addr[8:2];
                e_fault    = m_f;
                e_rdata    = m_rd;
                e_wdata    = m_nw;
                resp_at    = k + m_lat;
                busy_until = resp_at;
                rd_at      = m_rds ? k + 1 : -1;
                wr_at      = m_wrs ? k + m_lat - 1 : -1;
                accepts++;
            end
        end
        prev_rd = bus.mem_trig_read;
        prev_wr = bus.mem_trig_write;
    end

    task automatic do_req(input logic [5:0] op, input logic [31:0] a, input logic [31:0] w,
                          output logic [31:0] rd, output logic [1:0] f, output int lat);
        int n;
        rd = 32'd0; f = 2'b00; lat = -1;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = a; bus.req_wdata = w;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.req_ready && n < 20);
        if (!bus.req_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1 within 20 cycles");
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                rd = bus.resp_rdata; f = bus.resp_fault; lat = i;
                break;
            end
        end
        if (lat < 0) begin
            checks++; failures++;
            $display("FAIL resp_timeout: got no resp_valid expected one within 10 cycles");
        end
    endtask

    task automatic req_chk(input string name, input logic [5:0] op, input logic [31:0] a,
                           input logic [31:0] w, input logic [31:0] exp_rd,
                           input logic [1:0] exp_f, input int exp_lat);
        logic [31:0] rd;
        logic [1:0]  f;
        int          lat;
        do_req(op, a, w, rd, f, lat);
        chk({name, "_rdata"}, rd, exp_rd);
        chk({name, "_fault"}, 32'(f), 32'(exp_f));
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic rst_req(input logic [5:0] op, input logic [31:0] a, input logic [31:0] w, input int d);
        int n;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = a; bus.req_wdata = w;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.req_ready && n < 20);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (d) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] rdv, a, w;
        logic [1:0]  fv;
        int          lv, acc0, n;
        logic [5:0]  op;
        bus.req_valid = 1'b0; bus.req_op = 6'd0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        reset = 1'b1;
        for (int i = 0; i < 128; i++) seed_mem[i] = $urandom;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'd0);
        chk("rst_fault", 32'(bus.resp_fault), 32'd0);
        chk("rst_triggers", 32'({bus.mem_trig_read, bus.mem_trig_write}), 32'd0);
        chk("rst_addrs", 32'({bus.mem_read_addr, bus.mem_write_addr}), 32'd0);
        chk("rst_wdata", bus.mem_write_data, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check_en = 1'b1;

        req_chk("sw_beef", c_SW, 32'h10, 32'hDEADBEEF, 32'h0, 2'b00, 2);
        chk("mem4_beef", dmem[4], 32'hDEADBEEF);
        req_chk("lw_beef", c_LW, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00, 3);
        req_chk("sw_pat", c_SW, 32'h10, 32'h80FF7F01, 32'h0, 2'b00, 2);
        req_chk("lb_10", c_LB, 32'h10, 32'h0, 32'hFFFFFF80, 2'b00, 3);
        req_chk("lbu_11", c_LBU, 32'h11, 32'h0, 32'h000000FF, 2'b00, 3);
        req_chk("lb_12", c_LB, 32'h12, 32'h0, 32'h0000007F, 2'b00, 3);
        req_chk("lh_12", c_LH, 32'h12, 32'h0, 32'h00007F01, 2'b00, 3);
        req_chk("lhu_10", c_LHU, 32'h10, 32'h0, 32'h000080FF, 2'b00, 3);
        req_chk("sw_init", c_SW, 32'h10, 32'h11223344, 32'h0, 2'b00, 2);
        req_chk("sb_13", c_SB, 32'h13, 32'h000000AA, 32'h0, 2'b00, 4);
        req_chk("lw_sb", c_LW, 32'h10, 32'h0, 32'h112233AA, 2'b00, 3);
        req_chk("sh_10", c_SH, 32'h10, 32'h0000BEEF, 32'h0, 2'b00, 4);
        req_chk("lw_sh", c_LW, 32'h10, 32'h0, 32'hBEEF33AA, 2'b00, 3);
        req_chk("f_lw_mis", c_LW, 32'h12, 32'h0, 32'h0, 2'b01, 1);
        req_chk("f_sh_mis", c_SH, 32'h11, 32'h0, 32'h0, 2'b01, 1);
        req_chk("f_range", c_LW, 32'h200, 32'h0, 32'h0, 2'b10, 1);
        req_chk("f_op", 6'b000000, 32'h10, 32'h0, 32'h0, 2'b11, 1);
        req_chk("f_prio", 6'b000000, 32'h201, 32'h0, 32'h0, 2'b11, 1);

        // Reset while an SB sits in its capture cycle.
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_op = c_SB; bus.req_addr = 32'h13; bus.req_wdata = 32'h55;
        @(negedge clk);
        chk("abort_pre_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_resp", 32'(bus.resp_valid), 32'd0);
        repeat (4) @(negedge clk);
        chk("abort_mem4", dmem[4], 32'hBEEF33AA);
        req_chk("abort_lw", c_LW, 32'h10, 32'h0, 32'hBEEF33AA, 2'b00, 3);

        // Back-to-back stream with req_valid held high.
        acc0 = accepts;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.req_op    = (i % 2 == 0) ? c_LW : c_SW;
            bus.req_addr  = 32'($urandom_range(0, 127) * 4);
            bus.req_wdata = $urandom;
            n = 0;
            do begin @(negedge clk); n++; end while (!bus.req_ready && n < 20);
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        repeat (6) @(posedge clk);
        chk("stream_accepts", 32'(accepts - acc0), 32'd20);

        for (int i = 0; i < 300; i++) begin
            op = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 11) == 0) op = 6'($urandom_range(0, 63));
            n = $urandom_range(0, 9);
            a = (n == 0) ? $urandom : 32'($urandom_range(0, 511));
            if (n >= 5) a = a & ~32'h3;
            w = $urandom;
            if ($urandom_range(0, 9) == 0) rst_req(op, a, w, $urandom_range(0, 4));
            else do_req(op, a, w, rdv, fv, lv);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (8) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 128; i++) chk("final_mem", dmem[i], mdl_mem[i]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage front end of the MIPS pipeline. Sits directly upstream of the 128-word data memory and drives its readMem/writeMem/writeData/trigWrite/trigRead inputs.
- Converts byte-addressed MIPS load/store requests (LB, LH, LW, LBU, LHU, SB, SH, SW) into word-level memory trigger pulses.
- Performs read-modify-write for sub-word stores, and extracts plus sign- or zero-extends sub-word loads.
- Reports faults for illegal opcodes, out-of-range addresses and misaligned addresses.

Parameters:
- MEM_WORDS, 128, number of 32-bit words in data memory; the word index is addr[8:2].
- IDX_W, 7, width of the memory word index (log2 MEM_WORDS).

Ports:
- clk  input  1  single clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  high only in IDLE; request accepted when req_valid & req_ready at a clk edge
- req_op  input  6  MIPS opcode: 100000 LB, 100001 LH, 100011 LW, 100100 LBU, 100101 LHU, 101000 SB, 101001 SH, 101011 SW
- req_addr  input  32  byte address
- req_wdata  input  32  store data; the low byte/half/word is used
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  load result; 0 for stores and faults
- resp_fault  output  2  00 ok, 01 misaligned, 10 out of range, 11 illegal op
- mem_read_addr  output  IDX_W  to memory readMem
- mem_write_addr  output  IDX_W  to memory writeMem
- mem_write_data  output  32  to memory writeData
- mem_trig_read  output  1  to memory trigRead
- mem_trig_write  output  1  to memory trigWrite
- mem_read_data  input  32  from memory readData

Behaviour:
- All outputs are registered. Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=00, mem_* addresses and data=0, both triggers=0, state=IDLE.
- Byte order is big-endian: byte offset 0 is bits [31:24]; halfword offset 0 is [31:16].
- On accept, latch op, addr and wdata, then classify with this priority:
  - illegal op → 11
  - addr[31:9]≠0 → 10
  - half with addr[0]=1, or word with addr[1:0]≠0 → 01
- States:
  - IDLE: req_ready=1. On accept:
    - fault → RESP with the fault code
    - SW → WR with mem_write_data=wdata
    - any load, SB or SH → RD
  - RD: mem_trig_read=1, mem_read_addr=addr[8:2] → CAP.
  - CAP: mem_trig_read=0; capture mem_read_data.
    - Load → RESP: select the byte/half, then sign-extend (LB/LH) or zero-extend (LBU/LHU); LW passes through.
    - SB/SH → WR: the merged word replaces only the addressed byte/half with wdata[7:0]/[15:0].
  - WR: mem_trig_write=1, mem_write_addr=addr[8:2] → RESP.
  - RESP: both triggers=0, resp_valid=1 for exactly one cycle → IDLE.
- Triggers are never high together. Each trigger is high for exactly one cycle, and the following cycle is low, giving a clean rising edge per access.
- Latency from accept edge to the resp_valid cycle:
  - fault: 1 cycle
  - SW: 2 cycles
  - loads: 3 cycles
  - SB/SH: 4 cycles
- No pipelining; the next accept is possible in the cycle after RESP.
- req_valid while req_ready=0 is ignored and not queued; the requester must hold it.
- Faulting requests never assert either trigger.
- Address wrap is not supported: anything above 0x1FF faults with 10.
- Reset in any state returns to IDLE at the next edge with triggers low:
  - RMW aborted before WR issues no write.
  - Reset during WR: the write has already occurred on the trigger's rising edge.
  - No resp_valid is produced for an aborted request.

Test Plan:
- Reset then SW addr 0x10 wdata 0xDEADBEEF → trig_write pulses with write_addr=4, resp_valid 2 cycles after accept, fault 00; a following LW 0x10 returns 0xDEADBEEF after 3 cycles.
- Memory word 4 = 0x80FF7F01. LB 0x10→0xFFFFFF80, LBU 0x11→0x000000FF, LB 0x12→0x0000007F, LH 0x12→0x00007F01, LHU 0x10→0x000080FF.
- Word 4=0x11223344. SB 0x13 wdata 0xAA → word becomes 0x112233AA. SH 0x10 wdata 0xBEEF → 0xBEEF33AA. Each store shows read pulse, then write pulse, 4-cycle latency.
- LW 0x12 → fault 01; SH 0x11 → 01; LW 0x200 → 10; op 000000 → 11; op 000000 at addr 0x201 → 11 (priority). All respond in 1 cycle with no trigger pulse.
- Assert reset during CAP of SB 0x13 → no trig_write, no resp_valid, req_ready=1 next cycle, word 4 unchanged.
- Hold req_valid high with alternating LW/SW for 20 requests → exactly one accept per IDLE, triggers never simultaneously high, each trigger pulse exactly 1 cycle wide.
